// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result path: opcodes and the result entry
// that carries a selected result together with its status flags.
package alu_pkg;

   localparam int ALU_DATA_W = 32;

   localparam logic [2:0] OP_AND  = 3'b000;
   localparam logic [2:0] OP_OR   = 3'b001;
   localparam logic [2:0] OP_XOR  = 3'b010;
   localparam logic [2:0] OP_ADD  = 3'b011;
   localparam logic [2:0] OP_XNOR = 3'b100;

   // One buffered ALU result: the value plus the flags derived from it.
   typedef struct packed {
      logic [ALU_DATA_W-1:0] result;
      logic                  zero;
      logic                  neg;
      logic                  carry;
      logic                  parity;
      logic                  err;
   } alu_entry_t;

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational result select and flag generation. It turns the raw unit
// outputs into one alu_entry_t, ready to be registered by any ALU stage.
module alu_flag_gen
   import alu_pkg::*;
#(
   parameter int DATA_W = ALU_DATA_W
) (
   input  logic [2:0]        i_op,
   input  logic [DATA_W-1:0] i_and_s,
   input  logic [DATA_W-1:0] i_or_s,
   input  logic [DATA_W-1:0] i_xor_s,
   input  logic [DATA_W-1:0] i_add_s,
   input  logic              i_add_c,
   output alu_entry_t        o_entry
);

   logic [DATA_W-1:0] w_result;
   logic              w_err;

   // Pick the unit result for the opcode; illegal opcodes give 0 and err.
   always_comb begin
      // NOTE: every output gets a default first, so no path can infer a latch.
      w_result = '0;
      w_err    = 1'b0;
      case (i_op)
         OP_AND:  w_result = i_and_s;
         OP_OR:   w_result = i_or_s;
         OP_XOR:  w_result = i_xor_s;
         OP_ADD:  w_result = i_add_s;
         OP_XNOR: w_result = ~i_xor_s;
         default: w_err    = 1'b1;
      endcase
   end

   assign o_entry.result = w_result;
   assign o_entry.zero   = ~|w_result;
   assign o_entry.neg    = w_result[DATA_W-1];
   assign o_entry.carry  = (i_op == OP_ADD) & i_add_c;
   assign o_entry.parity = ^w_result;
   assign o_entry.err    = w_err;

endmodule

// File: rtl/alu_result_stage.sv
// Registered ALU output stage: selects a result, builds its flags, and holds
// it in a two-entry skid buffer (main + skid) behind a valid/ready handshake.
// A saturating counter tracks delivered results.
module alu_result_stage
   import alu_pkg::*;
#(
   parameter int DATA_W = ALU_DATA_W,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        in_op,
   input  logic [DATA_W-1:0] and_s,
   input  logic [DATA_W-1:0] or_s,
   input  logic [DATA_W-1:0] xor_s,
   input  logic [DATA_W-1:0] add_s,
   input  logic              add_c,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_result,
   output logic              out_zero,
   output logic              out_neg,
   output logic              out_carry,
   output logic              out_parity,
   output logic              out_err,
   input  logic              cnt_clr,
   output logic [CNT_W-1:0]  op_count
);

   alu_entry_t       w_entry;
   alu_entry_t       r_main;
   alu_entry_t       r_skid;
   logic             r_main_valid;
   logic             r_skid_valid;
   logic [CNT_W-1:0] r_count;
   logic             w_accept;
   logic             w_handshake;

   alu_flag_gen #(.DATA_W(DATA_W)) u_flag_gen (
      .i_op    (in_op),
      .i_and_s (and_s),
      .i_or_s  (or_s),
      .i_xor_s (xor_s),
      .i_add_s (add_s),
      .i_add_c (add_c),
      .o_entry (w_entry)
   );

   // in_ready comes straight from skid state, so out_ready never reaches it.
   assign in_ready    = ~r_skid_valid;
   assign w_accept    = in_valid & in_ready;
   assign w_handshake = r_main_valid & out_ready;

   // Move entries through main/skid in strict acceptance order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: entry registers are reset too, since out_result and the
         // flags must read 0 straight out of reset.
         r_main       <= '0;
         r_skid       <= '0;
         r_main_valid <= 1'b0;
         r_skid_valid <= 1'b0;
      end else if (!r_main_valid || w_handshake) begin
         // Main is free this cycle: the older skid entry has priority.
         if (r_skid_valid) begin
            r_main       <= r_skid;
            r_main_valid <= 1'b1;
            r_skid_valid <= 1'b0;
         end else if (w_accept) begin
            r_main       <= w_entry;
            r_main_valid <= 1'b1;
         end else begin
            r_main_valid <= 1'b0;
         end
      end else if (w_accept) begin
         // Main is stalled: park the new entry in the skid slot.
         r_skid       <= w_entry;
         r_skid_valid <= 1'b1;
      end
   end

   // Count output handshakes, saturating; a clear wins over a handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (cnt_clr) begin
         r_count <= '0;
      end else if (w_handshake && (r_count != {CNT_W{1'b1}})) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign out_valid  = r_main_valid;
   assign out_result = r_main.result;
   assign out_zero   = r_main.zero;
   assign out_neg    = r_main.neg;
   assign out_carry  = r_main.carry;
   assign out_parity = r_main.parity;
   assign out_err    = r_main.err;
   assign op_count   = r_count;

endmodule

// File: tb/tb_alu_result_stage.sv
// Scoreboard bench for alu_result_stage: the driver pushes hand-computed
// expected entries as inputs are accepted; a monitor pops and compares on
// every output handshake.
module tb_alu_result_stage;
   import alu_pkg::*;

   localparam int DATA_W = 32;
   localparam int CNT_W  = 4;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              in_valid;
   logic              in_ready;
   logic [2:0]        in_op;
   logic [DATA_W-1:0] and_s, or_s, xor_s, add_s;
   logic              add_c;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_result;
   logic              out_zero, out_neg, out_carry, out_parity, out_err;
   logic              cnt_clr;
   logic [CNT_W-1:0]  op_count;

   int n_tests = 0;
   int n_fail  = 0;
   alu_entry_t exp_q[$];

   always #5 clk = ~clk;

   alu_result_stage #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_op      (in_op),
      .and_s      (and_s),
      .or_s       (or_s),
      .xor_s      (xor_s),
      .add_s      (add_s),
      .add_c      (add_c),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_zero   (out_zero),
      .out_neg    (out_neg),
      .out_carry  (out_carry),
      .out_parity (out_parity),
      .out_err    (out_err),
      .cnt_clr    (cnt_clr),
      .op_count   (op_count)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic alu_entry_t mk(input logic [31:0] r, input logic z, input logic n,
                                     input logic c, input logic p, input logic e);
      alu_entry_t t;
      t.result = r;
      t.zero   = z;
      t.neg    = n;
      t.carry  = c;
      t.parity = p;
      t.err    = e;
      return t;
   endfunction

   // Monitor: compare each delivered result against the scoreboard head.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_output", 64'(out_valid), 64'd0);
         end else begin
            alu_entry_t e;
            e = exp_q.pop_front();
            check("deliver_result", 64'(out_result), 64'(e.result));
            check("deliver_flags", 64'({out_zero, out_neg, out_carry, out_parity, out_err}),
                  64'({e.zero, e.neg, e.carry, e.parity, e.err}));
         end
      end
   end

   // Drive one result set and hold it until accepted; record expectation.
   task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] o,
                       input logic [31:0] x, input logic [31:0] s, input logic c,
                       input alu_entry_t exp);
      bit ok = 0;
      in_op = op; and_s = a; or_s = o; xor_s = x; add_s = s; add_c = c;
      in_valid = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (in_ready) begin
            exp_q.push_back(exp);
            ok = 1;
         end
         @(posedge clk);
         #1;
         if (ok) break;
      end
      if (!ok) check("accept_timeout", 64'd0, 64'd1);
      in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      bit ok = 0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk);
         #1;
         if (exp_q.size() == 0) begin
            ok = 1;
            break;
         end
      end
      if (!ok) check("drain_timeout", 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_op = 3'b000;
      and_s = '0; or_s = '0; xor_s = '0; add_s = '0; add_c = 1'b0;
      out_ready = 1'b0; cnt_clr = 1'b0;
      #22;
      // Reset state
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_out_result", 64'(out_result), 64'd0);
      check("rst_flags", 64'({out_zero, out_neg, out_carry, out_parity, out_err}), 64'd0);
      check("rst_op_count", 64'(op_count), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Single-result vectors with out_ready high
      out_ready = 1'b1;
      send(3'b010, 32'h0, 32'h0, 32'hFFFF0000, 32'h0, 1'b0, mk(32'hFFFF0000, 0, 1, 0, 0, 0));
      wait_drain();
      check("count_after_xor", 64'(op_count), 64'd1);
      send(3'b011, 32'h0, 32'h0, 32'h0, 32'h00000000, 1'b1, mk(32'h0, 1, 0, 1, 0, 0));
      send(3'b000, 32'h12345678, 32'h0, 32'h0, 32'h0, 1'b1, mk(32'h12345678, 0, 0, 0, 1, 0));
      send(3'b001, 32'h0, 32'h80000001, 32'h0, 32'h0, 1'b1, mk(32'h80000001, 0, 1, 0, 0, 0));
      send(3'b111, 32'hDEADBEEF, 32'hFFFFFFFF, 32'h1, 32'h7, 1'b1, mk(32'h0, 1, 0, 0, 0, 1));
      wait_drain();
      check("count_after_illegal", 64'(op_count), 64'd5);

      // Back-pressure: fill main and skid
      out_ready = 1'b0;
      send(3'b100, 32'h0, 32'h0, 32'h0000000F, 32'h0, 1'b0, mk(32'hFFFFFFF0, 0, 1, 0, 0, 0));
      send(3'b000, 32'h1, 32'h0, 32'h0, 32'h0, 1'b0, mk(32'h00000001, 0, 0, 0, 1, 0));
      check("bp_in_ready_low", 64'(in_ready), 64'd0);
      check("bp_out_valid", 64'(out_valid), 64'd1);
      repeat (3) @(posedge clk);
      #1;
      check("bp_hold_result", 64'(out_result), 64'hFFFFFFF0);
      out_ready = 1'b1;
      wait_drain();
      check("bp_in_ready_back", 64'(in_ready), 64'd1);
      check("count_after_bp", 64'(op_count), 64'd7);

      // Streaming: accept and handshake in the same cycle
      send(3'b010, 32'h0, 32'h0, 32'hA5A5A5A5, 32'h0, 1'b0, mk(32'hA5A5A5A5, 0, 1, 0, 0, 0));
      send(3'b011, 32'h0, 32'h0, 32'h0, 32'h00000007, 1'b0, mk(32'h00000007, 0, 0, 0, 1, 0));
      send(3'b100, 32'h0, 32'h0, 32'hFFFFFFFF, 32'h0, 1'b0, mk(32'h00000000, 1, 0, 0, 0, 0));
      send(3'b001, 32'h0, 32'h00000003, 32'h0, 32'h0, 1'b0, mk(32'h00000003, 0, 0, 0, 0, 0));
      wait_drain();
      check("count_after_stream", 64'(op_count), 64'd11);

      // Counter clear, then saturation
      cnt_clr = 1'b1;
      @(posedge clk); #1;
      cnt_clr = 1'b0;
      check("count_cleared", 64'(op_count), 64'd0);
      for (int i = 1; i <= 17; i++) begin
         send(3'b010, 32'h0, 32'h0, 32'(i), 32'h0, 1'b0,
              mk(32'(i), 0, 0, 0, 1'($countones(i) % 2), 0));
      end
      wait_drain();
      check("count_saturated", 64'(op_count), 64'd15);

      // Clear concurrent with a handshake
      out_ready = 1'b0;
      send(3'b000, 32'h0000FF00, 32'h0, 32'h0, 32'h0, 1'b0, mk(32'h0000FF00, 0, 0, 0, 0, 0));
      cnt_clr = 1'b1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      cnt_clr = 1'b0;
      check("count_clr_vs_hs", 64'(op_count), 64'd0);
      check("clr_hs_drained", 64'(exp_q.size()), 64'd0);

      // Asynchronous reset with both entries full
      out_ready = 1'b0;
      send(3'b010, 32'h0, 32'h0, 32'h11111111, 32'h0, 1'b0, mk(32'h11111111, 0, 0, 0, 0, 0));
      send(3'b010, 32'h0, 32'h0, 32'h22222222, 32'h0, 1'b0, mk(32'h22222222, 0, 0, 0, 0, 0));
      check("pre_rst_in_ready", 64'(in_ready), 64'd0);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_out_valid", 64'(out_valid), 64'd0);
      check("async_rst_in_ready", 64'(in_ready), 64'd1);
      exp_q.delete();
      out_ready = 1'b1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      check("post_rst_no_stale", 64'(out_valid), 64'd0);
      check("post_rst_count", 64'(op_count), 64'd0);
      check("post_rst_in_ready", 64'(in_ready), 64'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
